mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter bus_width, default 16, giving the data word width.
REQ-002 SHALL have parameter DWELL, default 4 (range 1..255), giving the clock cycles spent on each channel.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: abort request, sampled only in SCAN.
REQ-007 SHALL have port continuous, input, 1 bit: 1 = loop forever, 0 = single pass; sampled on accepted start.
REQ-008 SHALL have port ch_en, input, 4 bits: channel enable mask (bit i = channel i); sampled on accepted start.
REQ-009 SHALL have ports d0, d1, d2, d3, input, bus_width bits each: channel words, captured on accepted start.
REQ-010 SHALL have ports q0, q1, q2, q3, output, bus_width bits each: held channel words driving the 4:1 mux data inputs.
REQ-011 SHALL have port s, output, 2 bits: registered select driving the 4:1 mux select.
REQ-012 SHALL have port valid, output, 1 bit: s and q0..q3 are stable and the dwell is active.
REQ-013 SHALL have port busy, output, 1 bit: high in SCAN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a single pass.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, SCAN, DONE.
REQ-016 SHALL, in IDLE with start=1 and ch_en!=0, accept start: capture d0..d3 into q0..q3 and latch ch_en and continuous; next cycle state=SCAN, busy=1, valid=1, s=lowest enabled index, dwell counter=0.
REQ-017 SHALL, in IDLE with start=1 and ch_en=0, capture nothing; next cycle state=DONE (done=1, valid=0, busy=0).
REQ-018 SHALL hold s for exactly DWELL consecutive cycles with valid=1; the dwell counter increments each cycle and clears on channel change.
REQ-019 SHALL, at the end of a dwell, advance s to the next higher enabled index and skip disabled channels (no cycle is spent on a disabled channel).
REQ-020 SHALL, at the end of the dwell of the highest enabled index: if latched continuous=1, wrap s to the lowest enabled index; otherwise go to DONE.
REQ-021 SHALL, in DONE, hold done=1, valid=0, busy=0 for one cycle, keep s unchanged, then return to IDLE.
REQ-022 SHALL, on stop=1 in SCAN, go to IDLE at the next edge with valid=0, busy=0, no done pulse, and s and q0..q3 held; stop SHALL take priority over dwell advance and wrap.
REQ-023 SHALL ignore start outside IDLE and SHALL ignore stop outside SCAN.
REQ-024 SHALL change q0..q3 only on an accepted start, so the mux data never changes during a scan.
REQ-025 SHALL hold s at its last value in IDLE, with valid=0.
REQ-026 SHALL drive all outputs directly from registers.

Reset
REQ-027 SHALL, while rst=1 and independent of clk, force state=IDLE, s=2'b00, q0..q3=0, valid=0, busy=0, done=0, dwell counter=0, latched ch_en=0, latched continuous=0.
REQ-028 SHALL abort any scan when rst asserts mid-operation, with no done pulse.
REQ-029 SHALL honour start on the first rising edge after rst deasserts.

Verification (DWELL=4, bus_width=16)
REQ-030 Single pass SHALL be covered: d0..d3=0x1111/0x2222/0x3333/0x4444, ch_en=4'b1111, continuous=0, one-cycle start -> q0..q3 = those words; s = 0,1,2,3 for 4 cycles each with valid=1 (16 cycles); then done=1 for 1 cycle; then IDLE with s=3.
REQ-031 Skip and wrap SHALL be covered: ch_en=4'b1010, continuous=1, start -> s sequence 1,1,1,1,3,3,3,3,1,... with valid always 1 and done never asserted.
REQ-032 Stop SHALL be covered: continuous=1, stop asserted in the 2nd cycle of s=2 -> next cycle valid=0, busy=0, done=0, s stays 2.
REQ-033 Empty mask SHALL be covered: ch_en=4'b0000, start -> done=1 one cycle later, valid never 1, q0..q3 unchanged.
REQ-034 Mid-scan reset SHALL be covered: rst asserted between clock edges during SCAN -> outputs zero immediately; after release, a start restarts cleanly from the lowest enabled index.
REQ-035 Busy start SHALL be covered: start pulse in SCAN with new d0=0xFFFF -> ignored; q0 keeps its old value and the scan sequence is unchanged.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 analog/digital mux: holds captured channel words,
// steps the registered select through the enabled channels with a fixed dwell.
module mux_scan_ctrl #(
    parameter int bus_width = 16,
    parameter int DWELL     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [3:0]           ch_en,
    input  logic [bus_width-1:0] d0,
    input  logic [bus_width-1:0] d1,
    input  logic [bus_width-1:0] d2,
    input  logic [bus_width-1:0] d3,
    output logic [bus_width-1:0] q0,
    output logic [bus_width-1:0] q1,
    output logic [bus_width-1:0] q2,
    output logic [bus_width-1:0] q3,
    output logic [1:0]           s,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start, s held, valid low
    // SCAN  | dwelling on s, valid and busy high
    // DONE  | one-cycle done pulse after a single pass
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    state_t               state_q;
    logic [bus_width-1:0] q0_q, q1_q, q2_q, q3_q;
    logic [1:0]           s_q;
    logic                 valid_q, busy_q, done_q;
    logic [7:0]           cnt_q;
    logic [3:0]           en_q;
    logic                 cont_q;

    logic [1:0] start_idx_d;
    logic [1:0] wrap_idx_d;
    logic [1:0] next_idx_d;
    logic       has_next_d;

    // Descending loops so the lowest qualifying index wins.
    always_comb begin
        start_idx_d = 2'd0;
        wrap_idx_d  = 2'd0;
        next_idx_d  = 2'd0;
        has_next_d  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en[i]) start_idx_d = 2'(i);
            if (en_q[i])  wrap_idx_d  = 2'(i);
            if (en_q[i] && (2'(i) > s_q)) begin
                next_idx_d = 2'(i);
                has_next_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q0_q    <= '0;
            q1_q    <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
            s_q     <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
            en_q    <= 4'd0;
            cont_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (ch_en != 4'd0) begin
                            q0_q    <= d0;
                            q1_q    <= d1;
                            q2_q    <= d2;
                            q3_q    <= d3;
                            en_q    <= ch_en;
                            cont_q  <= continuous;
                            s_q     <= start_idx_d;
                            cnt_q   <= 8'd0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end else begin
                            // Empty mask: report completion without touching the held words.
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (stop) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        if (has_next_d) begin
                            s_q   <= next_idx_d;
                            cnt_q <= 8'd0;
                        end else if (cont_q) begin
                            s_q   <= wrap_idx_d;
                            cnt_q <= 8'd0;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign q0    = q0_q;
    assign q1    = q1_q;
    assign q2    = q2_q;
    assign q3    = q3_q;
    assign s     = s_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
